// File: rtl/raster_scheduler.sv
// Frame scheduler: walks the triangle index buffer, fetches three vertices per
// triangle, offers them one at a time to the rasterizer and drains at frame end.
module raster_scheduler #(
  parameter int TRI_ADDR_WIDTH  = 12,
  parameter int VERT_ADDR_WIDTH = 12,
  parameter int MEM_LATENCY     = 2,
  parameter int DRAIN_CYCLES    = 40
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [TRI_ADDR_WIDTH-1:0]       triangle_count_in,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic [TRI_ADDR_WIDTH-1:0]       index_addr_out,
  input  logic [3*VERT_ADDR_WIDTH+12-1:0] index_data_in,
  output logic [VERT_ADDR_WIDTH-1:0]      vertex_addr_out,
  input  logic [127:0]                    vertex_data_in,
  output logic                            vertex_valid_out,
  input  logic                            rast_ready_in,
  output logic [127:0]                    vertex_out,
  output logic [11:0]                     color_out
);

  localparam int TW      = TRI_ADDR_WIDTH;
  localparam int VW      = VERT_ADDR_WIDTH;
  localparam int IW      = 3 * VW + 12;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [2:0]         LAT_LAST   = 3'(MEM_LATENCY);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_FETCH_INDEX  = 3'd1,
    S_FETCH_VERTEX = 3'd2,
    S_PRESENT      = 3'd3,
    S_DRAIN        = 3'd4,
    S_DONE         = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [TW-1:0]       count_r;
  logic [TW-1:0]       tri_r;
  logic [1:0]          vtx_r;
  logic [2:0]          lat_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic                drain_go_r;
  logic [IW-1:0]       index_word_r;
  logic                busy_r;
  logic                frame_done_r;
  logic [TW-1:0]       index_addr_r;
  logic [VW-1:0]       vertex_addr_r;
  logic                vertex_valid_r;
  logic [127:0]        vertex_r;
  logic [11:0]         color_r;

  logic                lat_done_s;
  logic                xfer_s;
  logic [TW:0]         tri_next_s;
  logic                more_tri_s;
  logic                drain_step_s;
  logic                drain_done_s;
  logic [VW-1:0]       next_vidx_s;

  assign lat_done_s   = (lat_r == LAT_LAST);
  assign xfer_s       = vertex_valid_r && rast_ready_in;
  // Extra bit keeps the t+1 < count test exact at the largest count
  assign tri_next_s   = {1'b0, tri_r} + {{TW{1'b0}}, 1'b1};
  assign more_tri_s   = (tri_next_s < {1'b0, count_r});
  assign drain_step_s = drain_go_r || rast_ready_in;
  assign drain_done_s = drain_step_s && (drain_cnt_r == DRAIN_LAST);

  // Vertex index for the fetch that follows the current transfer
  always_comb begin
    next_vidx_s = index_word_r[VW-1:0];
    case (vtx_r)
      2'd0:    next_vidx_s = index_word_r[2*VW-1:VW];
      2'd1:    next_vidx_s = index_word_r[3*VW-1:2*VW];
      default: next_vidx_s = index_word_r[VW-1:0];
    endcase
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_in) begin
          state_next_s = (triangle_count_in != {TW{1'b0}}) ? S_FETCH_INDEX : S_DONE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH_INDEX: begin
        if (lat_done_s) state_next_s = S_FETCH_VERTEX;
        else            state_next_s = S_FETCH_INDEX;
      end
      S_FETCH_VERTEX: begin
        if (lat_done_s) state_next_s = S_PRESENT;
        else            state_next_s = S_FETCH_VERTEX;
      end
      S_PRESENT: begin
        if (!xfer_s)               state_next_s = S_PRESENT;
        else if (vtx_r != 2'd2)    state_next_s = S_FETCH_VERTEX;
        else if (more_tri_s)       state_next_s = S_FETCH_INDEX;
        else                       state_next_s = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done_s) state_next_s = S_DONE;
        else              state_next_s = S_DRAIN;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register, wait counters and triangle/vertex bookkeeping
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= S_IDLE;
      count_r     <= {TW{1'b0}};
      tri_r       <= {TW{1'b0}};
      vtx_r       <= 2'd0;
      lat_r       <= 3'd0;
      drain_cnt_r <= {DRAIN_W{1'b0}};
      drain_go_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s != state_r) begin
        lat_r <= 3'd0;
      end else if (state_r == S_FETCH_INDEX || state_r == S_FETCH_VERTEX) begin
        lat_r <= lat_r + 3'd1;
      end else begin
        lat_r <= 3'd0;
      end
      // Counting begins on the first ready cycle and then runs regardless of ready
      if (state_r != S_DRAIN) begin
        drain_cnt_r <= {DRAIN_W{1'b0}};
        drain_go_r  <= 1'b0;
      end else if (drain_step_s) begin
        drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
        drain_go_r  <= 1'b1;
      end
      if (state_r == S_IDLE && start_in) begin
        count_r <= triangle_count_in;
        tri_r   <= {TW{1'b0}};
        vtx_r   <= 2'd0;
      end else if (xfer_s) begin
        if (vtx_r != 2'd2) begin
          vtx_r <= vtx_r + 2'd1;
        end else begin
          vtx_r <= 2'd0;
          tri_r <= tri_next_s[TW-1:0];
        end
      end
    end
  end

  // Registered outputs and fetched data
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      index_addr_r   <= {TW{1'b0}};
      vertex_addr_r  <= {VW{1'b0}};
      index_word_r   <= {IW{1'b0}};
      vertex_valid_r <= 1'b0;
      vertex_r       <= 128'd0;
      color_r        <= 12'd0;
    end else begin
      busy_r       <= (state_next_s != S_IDLE);
      frame_done_r <= (state_next_s == S_DONE);
      if (state_r == S_IDLE && start_in && triangle_count_in != {TW{1'b0}}) begin
        index_addr_r <= {TW{1'b0}};
      end else if (xfer_s && vtx_r == 2'd2 && more_tri_s) begin
        index_addr_r <= tri_next_s[TW-1:0];
      end
      // The first vertex address comes straight off the index bus
      if (state_r == S_FETCH_INDEX && lat_done_s) begin
        index_word_r  <= index_data_in;
        vertex_addr_r <= index_data_in[VW-1:0];
      end else if (xfer_s && vtx_r != 2'd2) begin
        vertex_addr_r <= next_vidx_s;
      end
      if (state_r == S_FETCH_VERTEX && lat_done_s) begin
        vertex_r       <= vertex_data_in;
        color_r        <= index_word_r[IW-1 -: 12];
        vertex_valid_r <= 1'b1;
      end else if (xfer_s) begin
        vertex_valid_r <= 1'b0;
      end
    end
  end

  assign busy_out         = busy_r;
  assign frame_done_out   = frame_done_r;
  assign index_addr_out   = index_addr_r;
  assign vertex_addr_out  = vertex_addr_r;
  assign vertex_valid_out = vertex_valid_r;
  assign vertex_out       = vertex_r;
  assign color_out        = color_r;

endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: latency-modelled buffers, a transfer-queue reference
// model checked every cycle, directed scenarios and randomized frames.
module tb_raster_scheduler;

  localparam int TW = 5;
  localparam int VW = 6;
  localparam int L  = 3;
  localparam int D  = 12;
  localparam int IW = 3 * VW + 12;

  localparam logic [127:0] V0 = 128'h3F800000_00000000_40000000_3F800000;
  localparam logic [127:0] V1 = 128'h3F800000_3E800000_40400000_C0000000;
  localparam logic [127:0] V2 = 128'h3F800000_BF000000_41200000_40A00000;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            start_in;
  logic [TW-1:0]   triangle_count_in;
  logic            busy_out;
  logic            frame_done_out;
  logic [TW-1:0]   index_addr_out;
  logic [IW-1:0]   index_data_in;
  logic [VW-1:0]   vertex_addr_out;
  logic [127:0]    vertex_data_in;
  logic            vertex_valid_out;
  logic            rast_ready_in;
  logic [127:0]    vertex_out;
  logic [11:0]     color_out;

  always #5 clk_in = ~clk_in;

  raster_scheduler #(
    .TRI_ADDR_WIDTH(TW), .VERT_ADDR_WIDTH(VW), .MEM_LATENCY(L), .DRAIN_CYCLES(D)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .triangle_count_in(triangle_count_in), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .index_addr_out(index_addr_out),
    .index_data_in(index_data_in), .vertex_addr_out(vertex_addr_out),
    .vertex_data_in(vertex_data_in), .vertex_valid_out(vertex_valid_out),
    .rast_ready_in(rast_ready_in), .vertex_out(vertex_out), .color_out(color_out)
  );

  // Buffers with an L-cycle read pipeline
  logic [IW-1:0]  imem  [0:(1<<TW)-1];
  logic [127:0]   vmem  [0:(1<<VW)-1];
  logic [IW-1:0]  ipipe [0:L-1];
  logic [127:0]   vpipe [0:L-1];
  always @(posedge clk_in) begin
    ipipe[0] <= imem[index_addr_out];
    vpipe[0] <= vmem[vertex_addr_out];
    for (int i = 1; i < L; i++) begin
      ipipe[i] <= ipipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
  end
  assign index_data_in  = ipipe[L-1];
  assign vertex_data_in = vpipe[L-1];

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [127:0]  vtx;
    logic [11:0]   col;
    logic [TW-1:0] ia;
    logic [VW-1:0] va;
  } xfer_t;

  xfer_t          exp_q[$];
  bit             exp_busy = 1'b0;
  longint         exp_done = -1;
  bit             drain_wait = 1'b0;
  bit             prev_valid = 1'b0, prev_ready = 1'b0, prev_xfer = 1'b0;
  logic [127:0]   prev_vtx;
  logic [11:0]    prev_col;
  int             xfer_cnt = 0, done_cnt = 0, busy_cycles = 0, valid_cycles = 0;
  longint         last_xfer_cyc = 0, done_cyc = 0;
  logic [127:0]   obs_vtx[$];
  logic [11:0]    obs_col[$];
  logic [TW-1:0]  obs_ia[$];

  // Reference model: a frame is the ordered list of its 3*count vertex transfers
  always @(negedge clk_in) begin : cmp
    xfer_t         e;
    logic [IW-1:0] w;
    logic [VW-1:0] va;
    bit            xf;
    if (!rst_n_in) begin
      chk("rst_busy", busy_out, 1'b0);
      chk("rst_frame_done", frame_done_out, 1'b0);
      chk("rst_valid", vertex_valid_out, 1'b0);
      chk("rst_index_addr", index_addr_out, 0);
      chk("rst_vertex_addr", vertex_addr_out, 0);
      chk("rst_vertex", vertex_out, 0);
      chk("rst_color", color_out, 0);
      exp_q.delete();
      exp_busy = 1'b0; exp_done = -1; drain_wait = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_xfer = 1'b0;
    end else begin
      chk("busy", busy_out, exp_busy);
      chk("frame_done", frame_done_out, cyc == exp_done);
      if (!exp_busy) chk("valid_idle", vertex_valid_out, 1'b0);
      if (prev_xfer) chk("valid_after_xfer", vertex_valid_out, 1'b0);
      if (prev_valid && !prev_ready) begin
        chk("valid_hold", vertex_valid_out, 1'b1);
        chk("vertex_hold", vertex_out, prev_vtx);
        chk("color_hold", color_out, prev_col);
      end
      if (busy_out) busy_cycles++;
      if (vertex_valid_out) valid_cycles++;
      xf = vertex_valid_out && rast_ready_in;
      if (xf) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got vertex %0h expected no transfer", vertex_out);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_vertex", vertex_out, e.vtx);
          chk("xfer_color", color_out, e.col);
          chk("xfer_index_addr", index_addr_out, e.ia);
          chk("xfer_vertex_addr", vertex_addr_out, e.va);
          if (exp_q.size() == 0) drain_wait = 1'b1;
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
        obs_vtx.push_back(vertex_out);
        obs_col.push_back(color_out);
        obs_ia.push_back(index_addr_out);
      end else if (drain_wait && rast_ready_in) begin
        exp_done = cyc + D;
        drain_wait = 1'b0;
      end
      if (frame_done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (exp_busy && cyc == exp_done) begin
        exp_busy = 1'b0;
        exp_done = -1;
      end else if (!exp_busy && start_in) begin
        exp_busy = 1'b1;
        for (int t = 0; t < int'(triangle_count_in); t++) begin
          w = imem[t];
          for (int k = 0; k < 3; k++) begin
            va = w[k*VW +: VW];
            e.vtx = vmem[va];
            e.col = w[IW-1 -: 12];
            e.ia  = TW'(t);
            e.va  = va;
            exp_q.push_back(e);
          end
        end
        if (triangle_count_in == '0) exp_done = cyc + 1;
      end
      prev_valid = vertex_valid_out;
      prev_ready = rast_ready_in;
      prev_vtx   = vertex_out;
      prev_col   = color_out;
      prev_xfer  = xf;
    end
  end

  longint start_cyc;

  task automatic start_frame(input int n);
    @(posedge clk_in); #1;
    start_in = 1'b1;
    triangle_count_in = TW'(n);
    start_cyc = cyc;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk_in); #1;
      if (rnd) rast_ready_in = ($urandom_range(0, 99) < 70);
      if (done_cnt != d0) got = 1'b1;
    end
    rast_ready_in = 1'b1;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_done: got no frame_done expected one within %0d cycles", budget);
    end
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < (1 << TW); i++) imem[i] = IW'({$urandom(), $urandom()});
    for (int i = 0; i < (1 << VW); i++) vmem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0, b0, n;
    bit found;
    logic [127:0] v_hold;
    longint rise_cyc;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    triangle_count_in = '0;
    rast_ready_in = 1'b1;
    rand_mem();
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1 chk("idle_after_reset", busy_out, 1'b0);

    // One triangle, literal vertices and colour
    imem[0] = {12'hF00, 6'd2, 6'd1, 6'd0};
    vmem[0] = V0; vmem[1] = V1; vmem[2] = V2;
    x0 = xfer_cnt; d0 = done_cnt;
    obs_vtx.delete(); obs_col.delete();
    start_frame(1);
    wait_done(400, 1'b0);
    chk("t1_xfers", xfer_cnt - x0, 3);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_done_latency", done_cyc - last_xfer_cyc, 13);
    if (obs_vtx.size() == 3) begin
      chk("t1_v0", obs_vtx[0], V0);
      chk("t1_v1", obs_vtx[1], V1);
      chk("t1_v2", obs_vtx[2], V2);
      for (int i = 0; i < 3; i++) chk("t1_color", obs_col[i], 12'hF00);
    end

    // Empty frame
    x0 = xfer_cnt; d0 = done_cnt; b0 = busy_cycles; n = valid_cycles;
    start_frame(0);
    wait_done(20, 1'b0);
    chk("t2_done_delay", done_cyc - start_cyc, 1);
    chk("t2_busy_cycles", busy_cycles - b0, 1);
    chk("t2_valid_cycles", valid_cycles - n, 0);
    chk("t2_xfers", xfer_cnt - x0, 0);
    chk("t2_done_pulses", done_cnt - d0, 1);

    // Backpressure for 10 cycles while a vertex is presented
    rand_mem();
    x0 = xfer_cnt;
    start_frame(2);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (vertex_valid_out) found = 1'b1;
      else begin @(posedge clk_in); #1; end
    end
    chk("t3_valid_seen", found, 1'b1);
    rast_ready_in = 1'b0;
    v_hold = vertex_out;
    repeat (10) begin
      @(posedge clk_in); #1;
      chk("t3_vertex_stable", vertex_out, v_hold);
    end
    rast_ready_in = 1'b1;
    wait_done(600, 1'b0);
    chk("t3_xfers", xfer_cnt - x0, 6);

    // Second start while a frame is running is ignored
    x0 = xfer_cnt; d0 = done_cnt;
    start_frame(3);
    repeat (5) @(posedge clk_in);
    #1 start_in = 1'b1; triangle_count_in = TW'(9);
    @(posedge clk_in);
    #1 start_in = 1'b0;
    wait_done(600, 1'b0);
    chk("t4_xfers", xfer_cnt - x0, 9);
    chk("t4_done_pulses", done_cnt - d0, 1);

    // Reset while triangle 1 is presented, then restart
    rand_mem();
    x0 = xfer_cnt; d0 = done_cnt;
    start_frame(3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (xfer_cnt - x0 >= 3 && vertex_valid_out) found = 1'b1;
      else begin @(posedge clk_in); #1; end
    end
    chk("t5_present_tri1", found, 1'b1);
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 chk("t5_valid_drop", vertex_valid_out, 1'b0);
    chk("t5_busy_drop", busy_out, 1'b0);
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    chk("t5_no_done", done_cnt - d0, 0);
    imem[1] = ~imem[0];
    x0 = xfer_cnt;
    obs_ia.delete();
    start_frame(1);
    wait_done(400, 1'b0);
    chk("t5_restart_xfers", xfer_cnt - x0, 3);
    if (obs_ia.size() > 0) chk("t5_restart_index_addr", obs_ia[0], 0);

    // Drain waits for ready after the final transfer
    x0 = xfer_cnt; d0 = done_cnt;
    start_frame(1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk_in); #1;
      if (xfer_cnt - x0 == 3) found = 1'b1;
    end
    chk("t6_last_xfer", found, 1'b1);
    rast_ready_in = 1'b0;
    repeat (100) @(posedge clk_in);
    #1;
    chk("t6_no_early_done", done_cnt - d0, 0);
    rast_ready_in = 1'b1;
    rise_cyc = cyc;
    wait_done(100, 1'b0);
    chk("t6_drain_from_rise", done_cyc - rise_cyc, 12);
    chk("t6_done_pulses", done_cnt - d0, 1);

    // Randomized frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      rand_mem();
      n = $urandom_range(1, 6);
      x0 = xfer_cnt;
      start_frame(n);
      wait_done(1500, 1'b1);
      chk("rand_xfers", xfer_cnt - x0, 3 * n);
    end

    // Largest count for the triangle address width
    x0 = xfer_cnt;
    start_frame(31);
    wait_done(3000, 1'b0);
    chk("max_count_xfers", xfer_cnt - x0, 93);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_scheduler.md
RASTER_SCHEDULER -- requirements
Module: raster_scheduler

Interface
REQ-001 SHALL have parameter TRI_ADDR_WIDTH, default 12, width of triangle index-buffer address and triangle count.
REQ-002 SHALL have parameter VERT_ADDR_WIDTH, default 12, width of vertex-buffer address.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, read latency in cycles of both buffers (range 1..7).
REQ-004 SHALL have parameter DRAIN_CYCLES, default 40, cycles to wait for the rasterizer pipeline to empty.
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start_in  input  1  one-cycle frame start request.
REQ-008 SHALL have port triangle_count_in  input  TRI_ADDR_WIDTH  triangles in frame; sampled with start_in.
REQ-009 SHALL have port busy_out  output  1  high in every state except Idle.
REQ-010 SHALL have port frame_done_out  output  1  one-cycle pulse at frame completion.
REQ-011 SHALL have port index_addr_out  output  TRI_ADDR_WIDTH  index-buffer read address.
REQ-012 SHALL have port index_data_in  input  3*VERT_ADDR_WIDTH+12  {color[11:0], i2, i1, i0}, i0 in LSBs.
REQ-013 SHALL have port vertex_addr_out  output  VERT_ADDR_WIDTH  vertex-buffer read address.
REQ-014 SHALL have port vertex_data_in  input  128  four 32-bit floats {w,z,y,x}, x in [31:0].
REQ-015 SHALL have port vertex_valid_out  output  1  vertex offered to rasterizer.
REQ-016 SHALL have port rast_ready_in  input  1  rasterizer ready (level).
REQ-017 SHALL have port vertex_out  output  128  registered vertex word.
REQ-018 SHALL have port color_out  output  12  registered triangle color, constant for all three vertices.

Function
REQ-019 SHALL implement states Idle, FetchIndex, FetchVertex, Present, Drain, Done.
REQ-020 SHALL in Idle on start_in: latch triangle_count_in, clear triangle counter t and vertex counter v; go FetchIndex if count>0, else Done.
REQ-021 SHALL ignore start_in in every state except Idle.
REQ-022 SHALL in FetchIndex drive index_addr_out=t, wait MEM_LATENCY cycles, register index_data_in, then go FetchVertex.
REQ-023 SHALL in FetchVertex drive vertex_addr_out=index v (i0,i1,i2 for v=0,1,2), wait MEM_LATENCY cycles, load vertex_out and color_out, then go Present.
REQ-024 SHALL in Present hold vertex_valid_out=1 and vertex_out/color_out stable until the cycle where vertex_valid_out&&rast_ready_in (transfer).
REQ-025 SHALL deassert vertex_valid_out the cycle after a transfer; never two transfers in consecutive cycles.
REQ-026 SHALL after transfer with v<2: v<=v+1, go FetchVertex.
REQ-027 SHALL after transfer with v==2: v<=0, t<=t+1; go FetchIndex if t+1<count, else Drain.
REQ-028 SHALL in Drain first wait for rast_ready_in high, then count DRAIN_CYCLES cycles, then go Done.
REQ-029 SHALL in Done assert frame_done_out for exactly one cycle and return to Idle next cycle.
REQ-030 SHALL hold index_addr_out and vertex_addr_out at last driven value outside their fetch states.
REQ-031 SHALL support count up to 2^TRI_ADDR_WIDTH-1 with no counter wrap; t compared at full width.
REQ-032 SHALL throttle on rast_ready_in only; vertex_valid_out never depends combinationally on rast_ready_in.

Reset
REQ-033 SHALL on rst_n_in low, asynchronously, enter Idle and drive busy_out=0, frame_done_out=0, vertex_valid_out=0, index_addr_out=0, vertex_addr_out=0, vertex_out=0, color_out=0, t=0, v=0.
REQ-034 SHALL on reset mid-frame abandon the frame with no frame_done_out pulse; a later start_in begins at triangle 0.
REQ-035 SHALL remain in Idle after rst_n_in rises until start_in.

Verification
REQ-036 SHALL test: count=1, index word {0xF00,2,1,0}, ready always high -> exactly 3 transfers of vertices 0,1,2, color_out=0xF00 each, one frame_done_out pulse DRAIN_CYCLES+1 cycles after the 3rd transfer.
REQ-037 SHALL test: count=0 -> frame_done_out high the cycle after Done entry, no vertex_valid_out, busy_out high exactly 1 cycle.
REQ-038 SHALL test: count=2, rast_ready_in low 10 cycles during Present -> vertex_out stable throughout, 6 transfers total, order i0,i1,i2 per triangle.
REQ-039 SHALL test: start_in pulsed again during FetchVertex -> ignored, triangle count and transfers unchanged.
REQ-040 SHALL test: rst_n_in low during Present of triangle 1 -> vertex_valid_out falls immediately, no frame_done_out; restart with count=1 fetches index address 0.
REQ-041 SHALL test: rast_ready_in held low 100 cycles after final transfer -> Drain counter does not start until rast_ready_in rises.
